// File: rtl/prbs_chk.sv
`default_nettype none
// ============================================================================
// Module   : prbs_chk
// Purpose  : Receive-side checker for the 8-bit parallel PRBS7 pattern
//            (s[n] = s[n-6] ^ s[n-7], bit 0 earliest in serial time).
//            It self-seeds from incoming words, declares lock after a run of
//            correctly predicted words, then counts bit errors and checked
//            words against a free-running local predictor.
// Ports    : clk          deserializer parallel clock
//            rst          synchronous active-high reset
//            in_valid     in_data carries a word this cycle
//            in_data      received word
//            clr_cnt      synchronous clear of counters and lost_lock
//            locked       checker is in LOCKED
//            err_flag     one-cycle pulse, last checked word had bit errors
//            lost_lock    sticky, set on every LOCKED->SEARCH transition
//            bit_err_cnt  saturating count of errored bits while LOCKED
//            word_cnt     saturating count of words compared while LOCKED
// Revision : 1.0  initial release
// ============================================================================
module prbs_chk #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_flag,
    output logic             lost_lock,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [7:0] c_LOCK_CNT   = 8'(LOCK_CNT);
    localparam logic [7:0] c_UNLOCK_CNT = 8'(UNLOCK_CNT);

    // Four spare bits absorb a popcount of up to 8 before saturation.
    localparam int               c_SUM_W   = CNT_W + 4;
    localparam logic [c_SUM_W-1:0] c_CNT_MAX = {{4{1'b0}}, {CNT_W{1'b1}}};

    // Next parallel word of the sequence, derived from the serial recurrence.
    function automatic logic [7:0] prbs_next(input logic [7:0] w);
        logic [7:0] b;
        b[0] = w[1] ^ w[2];
        b[1] = w[2] ^ w[3];
        b[2] = w[3] ^ w[4];
        b[3] = w[4] ^ w[5];
        b[4] = w[5] ^ w[6];
        b[5] = w[6] ^ w[7];
        b[6] = w[7] ^ b[0];
        b[7] = b[0] ^ b[1];
        return b;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]       state_q,       state_d;
    logic [7:0]       prev_word_q,   prev_word_d;
    logic             have_prev_q,   have_prev_d;
    logic [7:0]       exp_q,         exp_d;
    logic [7:0]       match_run_q,   match_run_d;
    logic [7:0]       err_run_q,     err_run_d;
    logic             err_flag_q,    err_flag_d;
    logic             lost_lock_q,   lost_lock_d;
    logic [CNT_W-1:0] bit_err_cnt_q, bit_err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q,    word_cnt_d;

    // ------------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------------
    logic               w_good;
    logic               w_lock_hit;
    logic [7:0]         w_err_vec;
    logic               w_err;
    logic               w_unlock_hit;
    logic [c_SUM_W-1:0] w_bit_sum;
    logic [CNT_W-1:0]   w_bit_sat;
    logic [CNT_W-1:0]   w_word_sat;

    // An all-zero word never occurs in PRBS7 but is a fixed point of the
    // predictor, so it is excluded to keep a dead link from locking.
    assign w_good = have_prev_q && (in_data == prbs_next(prev_word_q))
                    && (in_data != 8'h00);

    assign w_lock_hit = in_valid && (state_q == ST_SEARCH) && w_good
                        && ((match_run_q + 8'd1) == c_LOCK_CNT);

    assign w_err_vec    = in_data ^ exp_q;
    assign w_err        = |w_err_vec;
    assign w_unlock_hit = in_valid && (state_q == ST_LOCKED) && w_err
                          && ((err_run_q + 8'd1) == c_UNLOCK_CNT);

    assign w_bit_sum = {4'b0000, bit_err_cnt_q}
                     + {{(c_SUM_W-4){1'b0}}, popcount8(w_err_vec)};
    assign w_bit_sat = (w_bit_sum > c_CNT_MAX) ? {CNT_W{1'b1}}
                                               : w_bit_sum[CNT_W-1:0];
    assign w_word_sat = (word_cnt_q == {CNT_W{1'b1}}) ? word_cnt_q
                                                      : word_cnt_q + CNT_W'(1);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SEARCH: if (w_lock_hit)   state_d = ST_LOCKED;
            ST_LOCKED: if (w_unlock_hit) state_d = ST_SEARCH;
            default:                     state_d = ST_SEARCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        locked      = (state_q == ST_LOCKED);
        err_flag    = err_flag_q;
        lost_lock   = lost_lock_q;
        bit_err_cnt = bit_err_cnt_q;
        word_cnt    = word_cnt_q;
    end

    // ------------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------------
    always_comb begin
        prev_word_d   = prev_word_q;
        have_prev_d   = have_prev_q;
        exp_d         = exp_q;
        match_run_d   = match_run_q;
        err_run_d     = err_run_q;
        err_flag_d    = 1'b0;
        lost_lock_d   = lost_lock_q;
        bit_err_cnt_d = bit_err_cnt_q;
        word_cnt_d    = word_cnt_q;

        if (in_valid) begin
            if (state_q == ST_SEARCH) begin
                prev_word_d = in_data;
                have_prev_d = 1'b1;
                if (w_lock_hit) begin
                    match_run_d = 8'd0;
                    exp_d       = prbs_next(in_data);
                end else if (w_good) begin
                    match_run_d = match_run_q + 8'd1;
                end else begin
                    match_run_d = 8'd0;
                end
            end else begin
                // Predictor free-runs; it is never re-seeded from data.
                exp_d         = prbs_next(exp_q);
                word_cnt_d    = w_word_sat;
                bit_err_cnt_d = w_bit_sat;
                err_flag_d    = w_err;
                if (w_unlock_hit) begin
                    err_run_d   = 8'd0;
                    lost_lock_d = 1'b1;
                    prev_word_d = in_data;
                    have_prev_d = 1'b1;
                end else if (w_err) begin
                    err_run_d = err_run_q + 8'd1;
                end else begin
                    err_run_d = 8'd0;
                end
            end
        end

        // Clear wins over any same-cycle increment or lost_lock set.
        if (clr_cnt) begin
            bit_err_cnt_d = '0;
            word_cnt_d    = '0;
            lost_lock_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_word_q   <= 8'h00;
            have_prev_q   <= 1'b0;
            exp_q         <= 8'h00;
            match_run_q   <= 8'd0;
            err_run_q     <= 8'd0;
            err_flag_q    <= 1'b0;
            lost_lock_q   <= 1'b0;
            bit_err_cnt_q <= '0;
            word_cnt_q    <= '0;
        end else begin
            prev_word_q   <= prev_word_d;
            have_prev_q   <= have_prev_d;
            exp_q         <= exp_d;
            match_run_q   <= match_run_d;
            err_run_q     <= err_run_d;
            err_flag_q    <= err_flag_d;
            lost_lock_q   <= lost_lock_d;
            bit_err_cnt_q <= bit_err_cnt_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs_chk.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_chk
// Purpose  : Self-checking bench for prbs_chk. Drives a PRBS7 word stream
//            (optionally corrupted, constant, or gapped) into two checkers,
//            one with 32-bit and one with 4-bit counters, and compares their
//            outputs against expectations queued alongside the stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_prbs_chk;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       clr_cnt = 1'b0;

    logic        locked,   s_locked;
    logic        err_flag, s_err_flag;
    logic        lost_lock, s_lost_lock;
    logic [31:0] bit_err_cnt, word_cnt;
    logic [3:0]  s_bit_err_cnt, s_word_cnt;

    always #5 clk = ~clk;

    prbs_chk #(.LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clr_cnt(clr_cnt), .locked(locked), .err_flag(err_flag),
        .lost_lock(lost_lock), .bit_err_cnt(bit_err_cnt), .word_cnt(word_cnt)
    );

    prbs_chk #(.LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clr_cnt(clr_cnt), .locked(s_locked), .err_flag(s_err_flag),
        .lost_lock(s_lost_lock), .bit_err_cnt(s_bit_err_cnt),
        .word_cnt(s_word_cnt)
    );

    // Expected outputs after one clock; -1 means "not checked".
    typedef struct {
        int lk; int err; int ll; int wc; int bec; int wc4; int bec4;
    } exp_t;

    // A stimulus segment: n words, optionally constant, gapped, or with
    // clr_cnt on its last word; err_e/lk_e apply to every word, fin to the
    // last word only.
    typedef struct {
        int         n;
        bit         konst;
        bit         tog;
        bit         clr;
        logic [7:0] x;
        int         err_e;
        int         lk_e;
        exp_t       fin;
    } seg_t;

    exp_t       sb[$];
    seg_t       segs[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] gen;
    exp_t       nc;
    exp_t       e_w, e_i;
    logic [7:0] d_w;

    // Next word from the serial recurrence, built bit by bit.
    function automatic logic [7:0] ref_next(input logic [7:0] w);
        logic [15:0] s;
        s = {8'h00, w};
        for (int i = 8; i < 16; i++) begin
            s[i] = s[i-6] ^ s[i-7];
        end
        return s[15:8];
    endfunction

    function automatic exp_t ex(input int lk, input int ll, input int wc,
                                input int bec, input int wc4, input int bec4);
        exp_t e;
        e.lk = lk; e.err = -1; e.ll = ll; e.wc = wc; e.bec = bec;
        e.wc4 = wc4; e.bec4 = bec4;
        return e;
    endfunction

    function automatic seg_t sg(input int n, input bit konst, input bit tog,
                                input bit clr, input logic [7:0] x,
                                input int err_e, input int lk_e,
                                input exp_t fin);
        seg_t s;
        s.n = n; s.konst = konst; s.tog = tog; s.clr = clr; s.x = x;
        s.err_e = err_e; s.lk_e = lk_e; s.fin = fin;
        return s;
    endfunction

    task automatic chk(input string name, input longint act, input int req);
        if (req >= 0) begin
            n_vec++;
            if (act != longint'(req)) begin
                n_miss++;
                $display("FAIL %s: got %0d, expected %0d at %0t",
                         name, act, req, $time);
            end
        end
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        chk("locked",        longint'(locked),        e.lk);
        chk("locked4",       longint'(s_locked),      e.lk);
        chk("err_flag",      longint'(err_flag),      e.err);
        chk("err_flag4",     longint'(s_err_flag),    e.err);
        chk("lost_lock",     longint'(lost_lock),     e.ll);
        chk("lost_lock4",    longint'(s_lost_lock),   e.ll);
        chk("word_cnt",      longint'(word_cnt),      e.wc);
        chk("bit_err_cnt",   longint'(bit_err_cnt),   e.bec);
        chk("word_cnt4",     longint'(s_word_cnt),    e.wc4);
        chk("bit_err_cnt4",  longint'(s_bit_err_cnt), e.bec4);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c,
                        input logic r, input exp_t e);
        rst      = r;
        in_valid = v;
        in_data  = d;
        clr_cnt  = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic do_reset();
        exp_t z;
        z = ex(0, 0, 0, 0, 0, 0);
        z.err = 0;
        step(1'b0, 8'h00, 1'b0, 1'b1, z);
        step(1'b0, 8'h5A, 1'b0, 1'b1, z);
        rst = 1'b0;
        gen = 8'h08;
    endtask

    task automatic run_segs();
        for (int s = 0; s < segs.size(); s++) begin
            for (int k = 0; k < segs[s].n; k++) begin
                e_w     = nc;
                e_w.lk  = segs[s].lk_e;
                e_w.err = segs[s].err_e;
                if (k == segs[s].n - 1) begin
                    if (segs[s].fin.lk   >= 0) e_w.lk   = segs[s].fin.lk;
                    e_w.ll   = segs[s].fin.ll;
                    e_w.wc   = segs[s].fin.wc;
                    e_w.bec  = segs[s].fin.bec;
                    e_w.wc4  = segs[s].fin.wc4;
                    e_w.bec4 = segs[s].fin.bec4;
                end
                if (segs[s].konst) begin
                    d_w = segs[s].x;
                end else begin
                    gen = ref_next(gen);
                    d_w = gen ^ segs[s].x;
                end
                step(1'b1, d_w, segs[s].clr && (k == segs[s].n - 1), 1'b0, e_w);
                if (segs[s].tog) begin
                    // Idle cycle with junk data: nothing may move.
                    e_i     = nc;
                    e_i.lk  = e_w.lk;
                    e_i.err = 0;
                    step(1'b0, 8'hA5, 1'b0, 1'b0, e_i);
                end
            end
        end
        segs.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nc = ex(-1, -1, -1, -1, -1, -1);

        // Reset state of both instances.
        do_reset();

        // Acquire lock, then 100 clean words.
        segs.push_back(sg(16,  0, 0, 0, 8'h00, 0, 0, ex(0, 0, 0, 0, -1, -1)));
        segs.push_back(sg(1,   0, 0, 0, 8'h00, 0, 1, ex(1, 0, 0, 0, -1, -1)));
        segs.push_back(sg(100, 0, 0, 0, 8'h00, 0, 1, ex(1, 0, 100, 0, -1, -1)));
        // Isolated single-bit and two-bit errors.
        segs.push_back(sg(5,   0, 0, 0, 8'h00, 0, 1, ex(1, 0, 105, 0, -1, -1)));
        segs.push_back(sg(1,   0, 0, 0, 8'h01, 1, 1, ex(1, 0, 106, 1, -1, -1)));
        segs.push_back(sg(3,   0, 0, 0, 8'h00, 0, 1, ex(1, 0, 109, 1, -1, -1)));
        segs.push_back(sg(1,   0, 0, 0, 8'h81, 1, 1, ex(1, 0, 110, 3, -1, -1)));
        segs.push_back(sg(2,   0, 0, 0, 8'h00, 0, 1, ex(1, 0, 112, 3, -1, -1)));
        // Four consecutive all-bit errors: exit, sticky lost_lock, relock.
        segs.push_back(sg(3,   0, 0, 0, 8'hFF, 1, 1, ex(1, 0, 115, 27, -1, -1)));
        segs.push_back(sg(1,   0, 0, 0, 8'hFF, 1, 0, ex(0, 1, 116, 35, -1, -1)));
        segs.push_back(sg(16,  0, 0, 0, 8'h00, 0, 0, ex(0, 1, 116, 35, -1, -1)));
        segs.push_back(sg(1,   0, 0, 0, 8'h00, 0, 1, ex(1, 1, 116, 35, -1, -1)));
        // Clear on a counted word.
        segs.push_back(sg(1,   0, 0, 1, 8'h00, 0, 1, ex(1, 0, 0, 0, 0, 0)));
        // 20 errored bits over four separated words; 4-bit counters saturate.
        segs.push_back(sg(1,   0, 0, 0, 8'hFF, 1, 1, nc));
        segs.push_back(sg(1,   0, 0, 0, 8'h00, 0, 1, nc));
        segs.push_back(sg(1,   0, 0, 0, 8'h0F, 1, 1, nc));
        segs.push_back(sg(1,   0, 0, 0, 8'h00, 0, 1, nc));
        segs.push_back(sg(1,   0, 0, 0, 8'h0F, 1, 1, nc));
        segs.push_back(sg(1,   0, 0, 0, 8'h00, 0, 1, nc));
        segs.push_back(sg(1,   0, 0, 0, 8'h0F, 1, 1, ex(1, 0, 7, 20, 7, 15)));
        // Clear concurrent with an errored word.
        segs.push_back(sg(1,   0, 0, 1, 8'h0F, 1, 1, ex(1, 0, 0, 0, 0, 0)));
        segs.push_back(sg(20,  0, 0, 0, 8'h00, 0, 1, ex(1, 0, 20, 0, 15, 0)));
        // Clear concurrent with the unlocking word beats the lost_lock set.
        segs.push_back(sg(3,   0, 0, 0, 8'hFF, 1, 1, ex(1, 0, 23, 24, 15, 15)));
        segs.push_back(sg(1,   0, 0, 1, 8'hFF, 1, 0, ex(0, 0, 0, 0, 0, 0)));
        // Dead link: all-zero and all-one words must never lock.
        segs.push_back(sg(200, 1, 0, 0, 8'h00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        segs.push_back(sg(200, 1, 0, 0, 8'hFF, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        run_segs();

        // Gapped stream: lock point counted in valid words is unchanged.
        do_reset();
        segs.push_back(sg(16,  0, 1, 0, 8'h00, 0, 0, ex(0, 0, 0, 0, 0, 0)));
        segs.push_back(sg(1,   0, 1, 0, 8'h00, 0, 1, ex(1, 0, 0, 0, 0, 0)));
        segs.push_back(sg(10,  0, 1, 0, 8'h00, 0, 1, ex(1, 0, 10, 0, 10, 0)));
        segs.push_back(sg(2,   0, 1, 0, 8'h03, 1, 1, ex(1, 0, 12, 4, 12, 4)));
        run_segs();

        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs_chk.md
Name: prbs_chk

Overview:
- Receive-side checker for the 8-bit parallel PRBS7 test pattern. It sits directly downstream of the LVDS RX deserializer on the T120 loopback link.
- Self-seeds from the incoming words, declares lock, then counts bit errors and words checked against a free-running local predictor.
- Status and counters feed the board-level pass/fail LEDs and the debug readout.

Parameters:
- LOCK_CNT, 16, consecutive predicted-word matches required in SEARCH to enter LOCKED (1..255).
- UNLOCK_CNT, 4, consecutive erroneous words in LOCKED that force return to SEARCH (1..255).
- CNT_W, 32, width of bit_err_cnt and word_cnt.

Ports:
- clk  in  1  single clock, deserializer parallel clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data carries a word this cycle.
- in_data  in  8  received word; bit 0 is earliest in serial time.
- clr_cnt  in  1  synchronous clear of bit_err_cnt, word_cnt and lost_lock.
- locked  out  1  checker in LOCKED state.
- err_flag  out  1  one-cycle pulse: last checked word had at least one bit error (LOCKED only).
- lost_lock  out  1  sticky; set on any LOCKED->SEARCH transition.
- bit_err_cnt  out  CNT_W  saturating count of erroneous bits while LOCKED.
- word_cnt  out  CNT_W  saturating count of words compared while LOCKED.

Behaviour:
- Sequence definition: serial s[n] = s[n-6] ^ s[n-7]. next(w) gives the following word:
  - b[i] = w[i+1]^w[i+2] for i=0..5
  - b[6] = w[7]^b[0]
  - b[7] = b[0]^b[1]
  - Reference sequence: ... 0x86, 0xE2 ...
- Reset (rst=1 at clk edge), regardless of state: SEARCH; match/err run counters 0; have_prev=0; all outputs 0.
- in_valid=0: all state, counters and outputs hold; err_flag=0.
- SEARCH, on each valid word:
  - If have_prev=1, in_data == next(prev_word) and in_data != 0x00: match_run++.
  - Otherwise: match_run=0.
  - Always: prev_word<=in_data; have_prev<=1.
  - When match_run would reach LOCK_CNT: go to LOCKED; exp<=next(in_data); match_run<=0.
  - 0x00 is never a valid PRBS7 word; this rule blocks false lock on a dead link.
- LOCKED, on each valid word:
  - e = in_data ^ exp; exp<=next(exp). The predictor is free-running and never re-seeded from data.
  - word_cnt += 1; bit_err_cnt += popcount(e).
  - err_flag = (e!=0).
  - If e!=0: err_run++; else err_run=0.
  - When err_run would reach UNLOCK_CNT: go to SEARCH; lost_lock<=1; err_run<=0; have_prev<=1 with prev_word<=in_data.
  - The word that triggers the exit is still counted.
- Latency: all outputs registered; they reflect a valid word one cycle after it is presented.
- The lock-triggering word is not counted in word_cnt. locked rises one cycle after the (LOCK_CNT+1)-th consecutive good valid word following reset.
- Counters saturate at all-ones; no wrap.
- clr_cnt has priority over a same-cycle increment or lost_lock set: result is 0. clr_cnt does not affect state or locked.
- err_flag is 0 in SEARCH.

Test Plan:
- Reset, then continuous generator stream from seed 0x08 (0x86, 0xE2, ...) -> locked=1 one cycle after 17th word; then 100 words -> word_cnt=100, bit_err_cnt=0, err_flag never high.
- Locked; XOR one word with 0x01, a later word with 0x81 -> two single-cycle err_flag pulses; bit_err_cnt=3; locked stays 1.
- Locked; 4 consecutive words XOR 0xFF -> bit_err_cnt +32, locked=0 one cycle after 4th, lost_lock=1; 17 further good words -> relock.
- 200 valid words of 0x00, then 200 of 0xFF -> locked never asserts.
- Valid stream with in_valid toggling 1/0 each cycle -> identical lock point in valid-word count as scenario 1; counters unchanged on idle cycles.
- CNT_W=4; 20 errored bits over 4 non-consecutive errored words -> bit_err_cnt=15. Then clr_cnt concurrent with an errored word -> bit_err_cnt=0, lost_lock=0.
